eth_tx_arbiter: RTL and testbench



---
 rtl/eth_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter sharing the MAC TX byte stream among NUM_PORTS requesters.
// Optional build macro ETH_TX_ARB_STRICT_PRIO_EN gives port 0 absolute priority over the others.
module eth_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_FRAME = 1518
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_PORTS-1:0] req_data,
    input  logic [NUM_PORTS-1:0]   req_valid,
    input  logic [NUM_PORTS-1:0]   req_last,
    output logic [NUM_PORTS-1:0]   req_ready,
    output logic [7:0]             tx_data_out,
    output logic                   tx_valid_out,
    output logic                   tx_last_out,
    input  logic                   tx_ready_in,
    input  logic [7:0]             ifg_cycles,
    output logic                   grant_valid,
    output logic [2:0]             grant_id,
    output logic                   frame_done,
    output logic                   oversize_err
);
    // state | meaning
    // IDLE  | no grant; pick the next requester
    // XFER  | granted port's bytes pass straight through
    // DRAIN | frame truncated; discard its remainder up to the last byte
    // IFG   | inter-frame gap countdown
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, IFG} state_t;

    localparam int CW = $clog2(MAX_FRAME + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_FRAME - 1);
    localparam logic [2:0] PORT_MAX = 3'(NUM_PORTS - 1);

`ifdef ETH_TX_ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    state_t        state;
    logic [2:0]    rr_ptr;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    gap_cnt;

    logic [7:0] port_data [8];
    logic [7:0] valid_ext;
    logic [7:0] last_ext;
    logic [7:0] ready_ext;
    logic       cur_valid;
    logic       cur_last;
    logic       at_limit;
    logic       beat;
    logic       win_found;
    logic [2:0] win_id;
    logic [2:0] next_ptr;

    // Pad per-port views to 8 entries so a 3-bit grant_id always indexes in range.
    for (genvar i = 0; i < 8; i++) begin : g_pad
        if (i < NUM_PORTS) begin : g_used
            assign port_data[i] = req_data[8*i +: 8];
        end else begin : g_unused
            assign port_data[i] = 8'h00;
        end
    end

    assign valid_ext    = 8'(req_valid);
    assign last_ext     = 8'(req_last);
    assign cur_valid    = valid_ext[grant_id];
    assign cur_last     = last_ext[grant_id];
    assign at_limit     = (byte_cnt == CNT_LAST);
    assign beat         = (state == XFER) && cur_valid && tx_ready_in;
    assign tx_valid_out = (state == XFER) && cur_valid;
    assign tx_last_out  = tx_valid_out && (cur_last || at_limit);
    assign tx_data_out  = (state == XFER) ? port_data[grant_id] : 8'h00;
    assign next_ptr     = (grant_id == PORT_MAX) ? 3'd0 : grant_id + 3'd1;

    always_comb begin
        ready_ext = 8'h00;
        if (state == XFER) begin
            ready_ext[grant_id] = tx_ready_in;
        end else if (state == DRAIN) begin
            ready_ext[grant_id] = 1'b1;
        end
    end
    assign req_ready = ready_ext[NUM_PORTS-1:0];

    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        if (STRICT && valid_ext[0]) begin
            win_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                logic [2:0] idx;
                idx = 3'((int'(rr_ptr) + k) % NUM_PORTS);
                if (!win_found && valid_ext[idx] && !(STRICT && idx == 3'd0)) begin
                    win_found = 1'b1;
                    win_id    = idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 3'd0;
            byte_cnt     <= '0;
            gap_cnt      <= 8'd0;
            grant_valid  <= 1'b0;
            grant_id     <= 3'd0;
            frame_done   <= 1'b0;
            oversize_err <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            oversize_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_id    <= win_id;
                        grant_valid <= 1'b1;
                        byte_cnt    <= '0;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        byte_cnt <= byte_cnt + CW'(1);
                        if (cur_last || at_limit) begin
                            frame_done <= 1'b1;
                            // Under strict priority port 0 never moves the rotation.
                            if (!STRICT || grant_id != 3'd0) begin
                                rr_ptr <= next_ptr;
                            end
                        end
                        if (cur_last) begin
                            grant_valid <= 1'b0;
                            gap_cnt     <= ifg_cycles;
                            state       <= (ifg_cycles != 8'd0) ? IFG : IDLE;
                        end else if (at_limit) begin
                            oversize_err <= 1'b1;
                            state        <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cur_valid && cur_last) begin
                        grant_valid <= 1'b0;
                        gap_cnt     <= ifg_cycles;
                        state       <= (ifg_cycles != 8'd0) ? IFG : IDLE;
                    end
                end
                IFG: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: per-cycle reference model plus directed and random frame traffic.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
    localparam int NP   = 4;
    localparam int MAXF = 1518;
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8*NP-1:0] req_data = '0;
    logic [NP-1:0]   req_valid = '0;
    logic [NP-1:0]   req_last = '0;
    logic [NP-1:0]   req_ready;
    logic [7:0]      tx_data_out;
    logic            tx_valid_out;
    logic            tx_last_out;
    logic            tx_ready_in = 1'b1;
    logic [7:0]      ifg_cycles = 8'd0;
    logic            grant_valid;
    logic [2:0]      grant_id;
    logic            frame_done;
    logic            oversize_err;

    eth_tx_arbiter #(.NUM_PORTS(NP), .MAX_FRAME(MAXF)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_last_out(tx_last_out),
        .tx_ready_in(tx_ready_in), .ifg_cycles(ifg_cycles),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .frame_done(frame_done), .oversize_err(oversize_err)
    );

    always #5 clk = ~clk;

    // Requester contents: one byte queue and one last-flag queue per port.
    logic [7:0] pq [NP][$];
    bit         pl [NP][$];
    bit         acc [NP];
    bit         vrand = 1'b0;
    bit         ifg_rand = 1'b0;
    int         ready_pct = 100;

    // Reference model state.
    int m_owner = -1;
    int m_sent  = 0;
    int m_rr    = 0;
    int m_wait  = 0;
    bit m_drain = 1'b0;
    bit m_done  = 1'b0;
    bit m_ovs   = 1'b0;

    int grant_log[$];
    int gap_log[$];
    int len_log[$];
    int done_cnt = 0;
    int ovs_cnt  = 0;
    int obeats   = 0;
    int ungr     = 0;
    bit prev_gv  = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] v, input int rr);
        if (STRICT && v[0]) return 0;
        for (int k = 0; k < NP; k++) begin
            int i;
            i = (rr + k) % NP;
            if (v[i] && !(STRICT && i == 0)) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int o;
        int w;
        bit ev;
        logic [NP-1:0] er;
        o  = m_owner;
        ev = 1'b0;
        er = '0;
        if (o >= 0) begin
            ev    = !m_drain && req_valid[o];
            er[o] = m_drain ? 1'b1 : tx_ready_in;
        end
        chk("grant_valid", int'(grant_valid), int'(o >= 0));
        if (o >= 0) chk("grant_id", int'(grant_id), o);
        chk("req_ready", int'(req_ready), int'(er));
        chk("tx_valid", int'(tx_valid_out), int'(ev));
        if (ev) begin
            chk("tx_data", int'(tx_data_out), int'(pq[o][0]));
            chk("tx_last", int'(tx_last_out), int'(pl[o][0] || m_sent == MAXF - 1));
        end else begin
            chk("tx_last_quiet", int'(tx_last_out), 0);
        end
        chk("frame_done", int'(frame_done), int'(m_done));
        chk("oversize_err", int'(oversize_err), int'(m_ovs));

        if (frame_done) done_cnt++;
        if (oversize_err) ovs_cnt++;
        if (tx_valid_out && tx_ready_in) begin
            obeats++;
            if (tx_last_out) begin
                len_log.push_back(obeats);
                obeats = 0;
            end
        end
        if (grant_valid && !prev_gv) begin
            grant_log.push_back(int'(grant_id));
            gap_log.push_back(ungr);
            ungr = 0;
        end else if (!grant_valid) begin
            ungr++;
        end
        prev_gv = grant_valid;
        for (int p = 0; p < NP; p++) acc[p] = req_valid[p] && req_ready[p];

        m_done = 1'b0;
        m_ovs  = 1'b0;
        if (rst) begin
            m_owner = -1; m_rr = 0; m_wait = 0; m_drain = 1'b0; m_sent = 0; obeats = 0;
        end else if (o < 0) begin
            if (m_wait > 0) begin
                m_wait--;
            end else begin
                w = pick(req_valid, m_rr);
                if (w >= 0) begin
                    m_owner = w; m_sent = 0; m_drain = 1'b0;
                end
            end
        end else if (m_drain) begin
            if (req_valid[o] && req_last[o]) begin
                m_owner = -1; m_drain = 1'b0; m_wait = int'(ifg_cycles);
            end
        end else if (req_valid[o] && tx_ready_in) begin
            if (req_last[o] || m_sent == MAXF - 1) begin
                m_done = 1'b1;
                if (!STRICT || o != 0) m_rr = (o + 1) % NP;
                if (req_last[o]) begin
                    m_owner = -1; m_wait = int'(ifg_cycles);
                end else begin
                    m_ovs = 1'b1; m_drain = 1'b1;
                end
            end
            m_sent++;
        end
    end

    task automatic load(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            pq[p].push_back(8'($urandom));
            pl[p].push_back(i == len - 1);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (pq[p].size() > 0) begin
                req_data[8*p +: 8] = pq[p][0];
                req_last[p]        = pl[p][0];
                req_valid[p]       = vrand ? ($urandom_range(0, 99) < 70) : 1'b1;
            end else begin
                req_data[8*p +: 8] = 8'h00;
                req_last[p]        = 1'b0;
                req_valid[p]       = 1'b0;
            end
        end
        tx_ready_in = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && pq[p].size() > 0) begin
                void'(pq[p].pop_front());
                void'(pl[p].pop_front());
            end
        end
        if (ifg_rand) ifg_cycles = 8'($urandom_range(0, 4));
        drive();
    endtask

    function automatic bit quiet();
        for (int p = 0; p < NP; p++) if (pq[p].size() > 0) return 1'b0;
        return (m_owner < 0) && (m_wait == 0);
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            step();
            n++;
        end
        chk(nm, int'(n < budget), 1);
        repeat (3) step();
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_tx_valid", int'(tx_valid_out), 0);
        chk("rst_tx_last", int'(tx_last_out), 0);
        chk("rst_tx_data", int'(tx_data_out), 0);
        chk("rst_grant_valid", int'(grant_valid), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_oversize", int'(oversize_err), 0);
    endtask

    task automatic chk_grants(input string nm, input int base, input int e[6], input int n);
        chk({nm, "_count"}, grant_log.size() - base, n);
        for (int k = 0; k < n; k++) begin
            if (grant_log.size() > base + k) chk(nm, grant_log[base + k], e[k]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int base, lb, d0, o0, n, nfr;
        int e[6];
        drive();
        repeat (3) step();
        @(negedge clk);
        chk_reset_vals();
        step();
        rst = 1'b0;

        // Four ports, 64-byte frames, back-to-back.
        base = grant_log.size(); lb = len_log.size(); d0 = done_cnt;
        for (int p = 0; p < NP; p++) load(p, 64);
        load(0, 64);
        drive();
        wait_idle("to_rotation", 1500);
        if (STRICT) e = '{0, 0, 1, 2, 3, 0}; else e = '{0, 1, 2, 3, 0, 0};
        chk_grants("rotation_order", base, e, 5);
        for (int k = 0; k < 5; k++) chk("rotation_len", len_log[lb + k], 64);
        chk("rotation_done", done_cnt - d0, 5);
        chk("rotation_gap", gap_log[base + 1], 1);

        // Port 2 alone with a 12-cycle gap.
        ifg_cycles = 8'd12;
        base = grant_log.size(); lb = len_log.size();
        load(2, 10); load(2, 10);
        drive();
        wait_idle("to_ifg", 500);
        e = '{2, 2, 0, 0, 0, 0};
        chk_grants("ifg_grants", base, e, 2);
        chk("ifg_len0", len_log[lb], 10);
        chk("ifg_len1", len_log[lb + 1], 10);
        chk("ifg_gap", gap_log[base + 1], 13);

        // Oversize frame on port 1 followed by a short one.
        ifg_cycles = 8'd2;
        lb = len_log.size(); d0 = done_cnt; o0 = ovs_cnt;
        load(1, 1600); load(1, 5);
        drive();
        wait_idle("to_oversize", 4000);
        chk("trunc_len", len_log[lb], 1518);
        chk("after_trunc_len", len_log[lb + 1], 5);
        chk("trunc_ovs", ovs_cnt - o0, 1);
        chk("trunc_done", done_cnt - d0, 2);

        // Port 3 with a 50% downstream ready.
        ifg_cycles = 8'd0; ready_pct = 50; lb = len_log.size();
        load(3, 200);
        drive();
        wait_idle("to_backpressure", 2000);
        chk("bp_len", len_log[lb], 200);

        // Random traffic on every port.
        vrand = 1'b1; ready_pct = 70; ifg_rand = 1'b1;
        d0 = done_cnt; o0 = ovs_cnt; nfr = 0;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) begin
                load(p, int'($urandom_range(1, 40)));
                nfr++;
            end
        end
        drive();
        wait_idle("to_random", 8000);
        chk("rand_done", done_cnt - d0, nfr);
        chk("rand_ovs", ovs_cnt - o0, 0);

        // Reset in the middle of a port 0 frame.
        vrand = 1'b0; ready_pct = 100; ifg_rand = 1'b0; ifg_cycles = 8'd0;
        load(1, 8);
        drive();
        wait_idle("to_pre_reset", 200);
        load(0, 40);
        drive();
        n = 0;
        while (!(m_owner == 0 && m_sent >= 20) && n < 200) begin
            step();
            n++;
        end
        chk("to_beat20", int'(n < 200), 1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk_reset_vals();
        step();
        rst = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            pl[p].delete();
        end
        base = grant_log.size();
        load(0, 6); load(2, 6);
        drive();
        wait_idle("to_post_reset", 200);
        e = '{0, 2, 0, 0, 0, 0};
        chk_grants("post_reset_order", base, e, 2);

        // Ports 0 and 1 both backlogged.
        base = grant_log.size();
        for (int k = 0; k < 3; k++) begin
            load(0, 8);
            load(1, 8);
        end
        drive();
        wait_idle("to_alternate", 500);
        if (STRICT) e = '{0, 0, 0, 1, 1, 1}; else e = '{0, 1, 0, 1, 0, 1};
        chk_grants("alternate_order", base, e, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
